// File: rtl/brownout_seq_if.sv
// +---------------------------------------------------------------------------+
// | brownout_seq_if : control/status bundle for the brownout sequencer        |
// | Optional: BROUT_EVT_CNT_EN adds the 8-bit saturating event count.         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface brownout_seq_if;
  logic       enable;
  logic       cfg_wr;
  logic [2:0] vtrip_req;
  logic [2:0] otrip_req;
  logic       brout_in;
  logic       evt_clr;
  logic       det_ena;
  logic [2:0] vtrip;
  logic [2:0] otrip;
  logic       busy;
  logic       armed;
  logic       brownout;
  logic       brout_evt;
  logic       irq;
`ifdef BROUT_EVT_CNT_EN
  logic [7:0] evt_cnt;

  modport master (
    output enable, cfg_wr, vtrip_req, otrip_req, brout_in, evt_clr,
    input  det_ena, vtrip, otrip, busy, armed, brownout, brout_evt, irq, evt_cnt
  );
  modport slave (
    input  enable, cfg_wr, vtrip_req, otrip_req, brout_in, evt_clr,
    output det_ena, vtrip, otrip, busy, armed, brownout, brout_evt, irq, evt_cnt
  );
`else
  modport master (
    output enable, cfg_wr, vtrip_req, otrip_req, brout_in, evt_clr,
    input  det_ena, vtrip, otrip, busy, armed, brownout, brout_evt, irq
  );
  modport slave (
    input  enable, cfg_wr, vtrip_req, otrip_req, brout_in, evt_clr,
    output det_ena, vtrip, otrip, busy, armed, brownout, brout_evt, irq
  );
`endif
endinterface

`default_nettype wire

// File: rtl/brownout_seq.sv
// +---------------------------------------------------------------------------+
// | brownout_seq : enable/settle/blank sequencing and debounce of the         |
// | brownout comparator flag. Optional macro BROUT_EVT_CNT_EN adds evt_cnt.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module brownout_seq #(
  parameter int SETTLE_CYC = 64,
  parameter int BLANK_CYC  = 16,
  parameter int DEB_CYC    = 4
) (
  input  logic          osc_ck,
  input  logic          rst,
  brownout_seq_if.slave bus
);

  localparam int          DEB_W     = $clog2(DEB_CYC + 1);
  localparam logic [11:0] SETTLE_LD = 12'(SETTLE_CYC - 1);
  localparam logic [11:0] BLANK_LD  = 12'(BLANK_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ARMED  = 2'd2;
  localparam logic [1:0] S_BLANK  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             brownout_q, brownout_d;
  logic [2:0]       vtrip_q, vtrip_d;
  logic [2:0]       otrip_q, otrip_d;
  logic             evt_q, evt_d;
  logic             irq_q, irq_d;
  logic             cfg_ok;

  // State register
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a disable wins over everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = S_OFF;
      cnt_d   = 12'd0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
        S_SETTLE: begin
          if (cnt_q == 12'd0) state_d = S_ARMED;
          else                cnt_d   = cnt_q - 12'd1;
        end
        S_ARMED: begin
          if (bus.cfg_wr) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end
        end
        default: begin
          if (bus.cfg_wr)           cnt_d   = BLANK_LD;
          else if (cnt_q == 12'd0)  state_d = S_ARMED;
          else                      cnt_d   = cnt_q - 12'd1;
        end
      endcase
    end
  end

  // Codes, debounce and event datapath
  assign cfg_ok = bus.cfg_wr && (state_q != S_SETTLE);

  always_comb begin
    vtrip_d    = cfg_ok ? bus.vtrip_req : vtrip_q;
    otrip_d    = cfg_ok ? bus.otrip_req : otrip_q;
    deb_d      = '0;
    brownout_d = brownout_q;
    if (!bus.enable || state_q == S_SETTLE) begin
      brownout_d = 1'b0;
    end else if (state_q == S_ARMED && !bus.cfg_wr) begin
      if (bus.brout_in != brownout_q) begin
        if (deb_q == DEB_LAST) brownout_d = ~brownout_q;
        else                   deb_d      = deb_q + DEB_W'(1);
      end
    end
    // brownout can only rise through the ARMED debounce path
    irq_d = brownout_d & ~brownout_q;
    evt_d = irq_d ? 1'b1 : (bus.evt_clr ? 1'b0 : evt_q);
  end

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      deb_q      <= '0;
      brownout_q <= 1'b0;
      vtrip_q    <= 3'b000;
      otrip_q    <= 3'b000;
      evt_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      brownout_q <= brownout_d;
      vtrip_q    <= vtrip_d;
      otrip_q    <= otrip_d;
      evt_q      <= evt_d;
      irq_q      <= irq_d;
    end
  end

`ifdef BROUT_EVT_CNT_EN
  logic [7:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (irq_d && evt_cnt_q != 8'hFF) evt_cnt_d = evt_cnt_q + 8'd1;
  end

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) evt_cnt_q <= 8'h00;
    else     evt_cnt_q <= evt_cnt_d;
  end

  assign bus.evt_cnt = evt_cnt_q;
`endif

  // Output decode
  logic det_ena_o, busy_o, armed_o;

  always_comb begin
    det_ena_o = (state_q != S_OFF);
    busy_o    = (state_q == S_SETTLE) || (state_q == S_BLANK);
    armed_o   = (state_q == S_ARMED);
  end

  assign bus.det_ena   = det_ena_o;
  assign bus.busy      = busy_o;
  assign bus.armed     = armed_o;
  assign bus.brownout  = brownout_q;
  assign bus.vtrip     = vtrip_q;
  assign bus.otrip     = otrip_q;
  assign bus.brout_evt = evt_q;
  assign bus.irq       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_brownout_seq.sv
// +---------------------------------------------------------------------------+
// | tb_brownout_seq : directed self-checking bench for brownout_seq           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_brownout_seq;
  logic osc_ck = 1'b0;
  logic rst    = 1'b1;
  int   errors = 0;
  int   checks = 0;

  brownout_seq_if bus();

  brownout_seq #(.SETTLE_CYC(64), .BLANK_CYC(16), .DEB_CYC(4)) dut (
    .osc_ck (osc_ck),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 osc_ck = ~osc_ck;

  // Inputs change and outputs are sampled on the falling edge
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge osc_ck);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 0; bus.cfg_wr = 0; bus.vtrip_req = 0; bus.otrip_req = 0;
    bus.brout_in = 0; bus.evt_clr = 0;
    steps(2);
    checks++; if ({bus.det_ena, bus.busy, bus.armed, bus.brownout} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.det_ena, bus.busy, bus.armed, bus.brownout}); end
    checks++; if ({bus.brout_evt, bus.irq, bus.vtrip, bus.otrip} !== 8'h00) begin errors++; $display("FAIL reset_evt_codes got=%h exp=00", {bus.brout_evt, bus.irq, bus.vtrip, bus.otrip}); end
    rst = 1'b0;
    steps(1);
  endtask

  task automatic test_settle();
    int n, irqs;
    bus.enable = 1; bus.brout_in = 1;
    steps(1);
    checks++; if ({bus.det_ena, bus.busy, bus.armed} !== 3'b110) begin errors++; $display("FAIL settle_start got=%b exp=110", {bus.det_ena, bus.busy, bus.armed}); end
    n = 0; irqs = 0;
    while (bus.busy && n < 200) begin n++; steps(1); irqs += int'(bus.irq); end
    checks++; if (n !== 64) begin errors++; $display("FAIL settle_len got=%0d exp=64", n); end
    checks++; if ({bus.armed, bus.brownout} !== 2'b10) begin errors++; $display("FAIL settle_armed got=%b exp=10", {bus.armed, bus.brownout}); end
    for (int i = 0; i < 3; i++) begin steps(1); irqs += int'(bus.irq); end
    checks++; if (bus.brownout !== 1'b0) begin errors++; $display("FAIL settle_deb_early got=%b exp=0", bus.brownout); end
    steps(1); irqs += int'(bus.irq);
    checks++; if ({bus.brownout, bus.irq, bus.brout_evt} !== 3'b111) begin errors++; $display("FAIL settle_rise got=%b exp=111", {bus.brownout, bus.irq, bus.brout_evt}); end
    for (int i = 0; i < 5; i++) begin steps(1); irqs += int'(bus.irq); end
    checks++; if (irqs !== 1) begin errors++; $display("FAIL settle_irq_count got=%0d exp=1", irqs); end
  endtask

  task automatic test_glitch();
    int irqs, hi;
    bus.brout_in = 0;
    steps(4);
    checks++; if ({bus.brownout, bus.irq} !== 2'b00) begin errors++; $display("FAIL glitch_fall got=%b exp=00", {bus.brownout, bus.irq}); end
    bus.evt_clr = 1; steps(1); bus.evt_clr = 0;
    checks++; if (bus.brout_evt !== 1'b0) begin errors++; $display("FAIL glitch_evt_clr got=%b exp=0", bus.brout_evt); end
    irqs = 0; hi = 0;
    bus.brout_in = 1;
    for (int i = 0; i < 3; i++) begin steps(1); irqs += int'(bus.irq); hi += int'(bus.brownout); end
    bus.brout_in = 0;
    for (int i = 0; i < 6; i++) begin steps(1); irqs += int'(bus.irq); hi += int'(bus.brownout); end
    checks++; if (irqs !== 0 || hi !== 0) begin errors++; $display("FAIL glitch_reject irqs=%0d hi=%0d exp=0/0", irqs, hi); end
    bus.brout_in = 1;
    steps(3);
    checks++; if (bus.brownout !== 1'b0) begin errors++; $display("FAIL glitch_3rd got=%b exp=0", bus.brownout); end
    steps(1);
    checks++; if ({bus.brownout, bus.irq} !== 2'b11) begin errors++; $display("FAIL glitch_4th got=%b exp=11", {bus.brownout, bus.irq}); end
    steps(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL glitch_irq_width got=%b exp=0", bus.irq); end
    bus.brout_in = 0;
    steps(4);
    checks++; if (bus.brownout !== 1'b0) begin errors++; $display("FAIL glitch_release got=%b exp=0", bus.brownout); end
  endtask

  task automatic test_blank();
    int n, irqs;
    bus.vtrip_req = 3'b101; bus.otrip_req = 3'b010; bus.cfg_wr = 1;
    steps(1); bus.cfg_wr = 0;
    checks++; if ({bus.vtrip, bus.otrip} !== 6'b101_010) begin errors++; $display("FAIL blank_codes got=%b exp=101010", {bus.vtrip, bus.otrip}); end
    checks++; if ({bus.busy, bus.armed} !== 2'b10) begin errors++; $display("FAIL blank_busy got=%b exp=10", {bus.busy, bus.armed}); end
    n = 0; irqs = 0;
    while (bus.busy && n < 40) begin
      bus.brout_in = (n >= 2 && n < 8);
      n++; steps(1); irqs += int'(bus.irq);
    end
    bus.brout_in = 0;
    checks++; if (n !== 16) begin errors++; $display("FAIL blank_len got=%0d exp=16", n); end
    checks++; if ({bus.armed, bus.brownout, 1'b0} !== 3'b100 || irqs !== 0) begin errors++; $display("FAIL blank_mask armed=%b brownout=%b irqs=%0d exp=1/0/0", bus.armed, bus.brownout, irqs); end
    bus.vtrip_req = 3'b001; bus.otrip_req = 3'b011; bus.cfg_wr = 1;
    steps(1); bus.cfg_wr = 0;
    steps(9);
    bus.vtrip_req = 3'b110; bus.otrip_req = 3'b100; bus.cfg_wr = 1;
    steps(1); bus.cfg_wr = 0;
    checks++; if ({bus.vtrip, bus.otrip} !== 6'b110_100) begin errors++; $display("FAIL blank_restart_codes got=%b exp=110100", {bus.vtrip, bus.otrip}); end
    n = 0;
    while (bus.busy && n < 40) begin n++; steps(1); end
    checks++; if (n !== 16 || bus.armed !== 1'b1) begin errors++; $display("FAIL blank_restart_len got=%0d armed=%b exp=16/1", n, bus.armed); end
  endtask

  task automatic test_disable();
    int n;
    bus.brout_in = 1;
    steps(4);
    checks++; if ({bus.brownout, bus.irq} !== 2'b11) begin errors++; $display("FAIL dis_rise got=%b exp=11", {bus.brownout, bus.irq}); end
    bus.vtrip_req = 3'b011; bus.otrip_req = 3'b101; bus.cfg_wr = 1;
    steps(1); bus.cfg_wr = 0; bus.brout_in = 0;
    steps(3);
    checks++; if ({bus.busy, bus.brownout, bus.vtrip} !== 5'b11_011) begin errors++; $display("FAIL dis_blank_hold got=%b exp=11011", {bus.busy, bus.brownout, bus.vtrip}); end
    bus.enable = 0;
    steps(1);
    checks++; if ({bus.det_ena, bus.busy, bus.armed, bus.brownout} !== 4'b0000) begin errors++; $display("FAIL dis_off got=%b exp=0000", {bus.det_ena, bus.busy, bus.armed, bus.brownout}); end
    checks++; if ({bus.brout_evt, bus.vtrip, bus.otrip} !== 7'b1_011_101) begin errors++; $display("FAIL dis_retain got=%b exp=1011101", {bus.brout_evt, bus.vtrip, bus.otrip}); end
    steps(1);
    bus.enable = 1;
    steps(1);
    bus.vtrip_req = 3'b111; bus.otrip_req = 3'b111; bus.cfg_wr = 1;
    steps(1); bus.cfg_wr = 0;
    checks++; if ({bus.busy, bus.vtrip, bus.otrip} !== 7'b1_011_101) begin errors++; $display("FAIL settle_cfg_ignored got=%b exp=1011101", {bus.busy, bus.vtrip, bus.otrip}); end
    n = 1;
    while (bus.busy && n < 200) begin n++; steps(1); end
    checks++; if (n !== 64 || bus.armed !== 1'b1) begin errors++; $display("FAIL resettle_len got=%0d armed=%b exp=64/1", n, bus.armed); end
  endtask

  task automatic test_sticky();
    bus.evt_clr = 1; steps(1); bus.evt_clr = 0;
    checks++; if (bus.brout_evt !== 1'b0) begin errors++; $display("FAIL sticky_clr0 got=%b exp=0", bus.brout_evt); end
    bus.brout_in = 1;
    steps(3);
    bus.evt_clr = 1; steps(1); bus.evt_clr = 0;
    checks++; if ({bus.brout_evt, bus.irq} !== 2'b11) begin errors++; $display("FAIL sticky_set_wins got=%b exp=11", {bus.brout_evt, bus.irq}); end
    bus.evt_clr = 1; steps(1); bus.evt_clr = 0;
    checks++; if ({bus.brout_evt, bus.brownout} !== 2'b01) begin errors++; $display("FAIL sticky_clr got=%b exp=01", {bus.brout_evt, bus.brownout}); end
    bus.brout_in = 0;
    steps(4);
  endtask

`ifdef BROUT_EVT_CNT_EN
  task automatic test_evt_cnt();
    checks++; if (bus.evt_cnt !== 8'd4) begin errors++; $display("FAIL evt_cnt_initial got=%0d exp=4", bus.evt_cnt); end
    for (int k = 0; k < 100; k++) begin bus.brout_in = 1; steps(4); bus.brout_in = 0; steps(4); end
    checks++; if (bus.evt_cnt !== 8'd104) begin errors++; $display("FAIL evt_cnt_104 got=%0d exp=104", bus.evt_cnt); end
    for (int k = 0; k < 200; k++) begin bus.brout_in = 1; steps(4); bus.brout_in = 0; steps(4); end
    checks++; if (bus.evt_cnt !== 8'hFF) begin errors++; $display("FAIL evt_cnt_sat got=%h exp=ff", bus.evt_cnt); end
  endtask
`endif

  task automatic test_async_reset();
    bus.enable = 0; steps(1);
    bus.enable = 1; steps(10);
    checks++; if ({bus.busy, bus.det_ena} !== 2'b11) begin errors++; $display("FAIL areset_pre got=%b exp=11", {bus.busy, bus.det_ena}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.det_ena, bus.busy, bus.armed, bus.brownout, bus.brout_evt, bus.irq, bus.vtrip, bus.otrip} !== 12'h000) begin errors++; $display("FAIL areset_now got=%h exp=000", {bus.det_ena, bus.busy, bus.armed, bus.brownout, bus.brout_evt, bus.irq, bus.vtrip, bus.otrip}); end
`ifdef BROUT_EVT_CNT_EN
    checks++; if (bus.evt_cnt !== 8'h00) begin errors++; $display("FAIL areset_evt_cnt got=%h exp=00", bus.evt_cnt); end
`endif
    steps(1);
    bus.enable = 0; rst = 1'b0;
    steps(1);
  endtask

  initial begin
    test_reset();
    test_settle();
    test_glitch();
    test_blank();
    test_disable();
    test_sticky();
`ifdef BROUT_EVT_CNT_EN
    test_evt_cnt();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
